// File: rtl/mood_pkg.sv
// Shared encodings for the mood level regulator: FSM states, override direction
// and the counter command issued by the FSM to the stimulus qualifier.
package mood_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_OVERRIDE = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  typedef enum logic [1:0] {
    CNT_KEEP  = 2'd0,
    CNT_LOAD1 = 2'd1,
    CNT_INCR  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/stim_qualifier.sv
// Reduces the stimulus vector to a request/direction pair and owns the shared
// filter/hold counter, whose updates are commanded by the regulator FSM.
module stim_qualifier
  import mood_pkg::*;
#(
  parameter int unsigned          N_STIM       = 7,
  parameter logic [N_STIM-1:0]    INC_MASK     = 7'b0000010,
  parameter logic [N_STIM-1:0]    DEC_MASK     = 7'b0000000,
  parameter bit                   INC_PRIORITY = 1'b1,
  parameter int unsigned          FILTER_LEN   = 4,
  parameter int unsigned          HOLD_CYCLES  = 8,
  parameter int unsigned          CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_STIM-1:0] stimuli,
  input  cnt_op_e           cnt_op,
  output logic              req,
  output logic              req_dir,
  output logic              filter_done,
  output logic              hold_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             req_inc;
  logic             req_dec;
  logic [CNT_W-1:0] cnt;

  assign req_inc = |(stimuli & INC_MASK);
  assign req_dec = |(stimuli & DEC_MASK);
  assign req     = req_inc | req_dec;

  // Conflicting masks resolve through the priority parameter.
  always_comb begin
    req_dir = DIR_INC;
    if (req_inc && req_dec) begin
      req_dir = INC_PRIORITY ? DIR_INC : DIR_DEC;
    end else if (req_dec) begin
      req_dir = DIR_DEC;
    end
  end

  // filter_done looks one edge ahead: the edge that would make cnt reach FILTER_LEN.
  assign filter_done = (32'(cnt) + 32'd1) >= FILTER_LEN;
  assign hold_done   = 32'(cnt) >= HOLD_CYCLES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      unique case (cnt_op)
        CNT_LOAD1: cnt <= CNT_W'(1);
        CNT_INCR:  if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        default:   cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mood_regulator.sv
// Arbitrates between the state controller's inc/dec requests and filtered
// external stimuli that can force one mood level up or down.
module mood_regulator
  import mood_pkg::*;
#(
  parameter int unsigned          N_STIM       = 7,
  parameter logic [N_STIM-1:0]    INC_MASK     = 7'b0000010,
  parameter logic [N_STIM-1:0]    DEC_MASK     = 7'b0000000,
  parameter bit                   INC_PRIORITY = 1'b1,
  parameter int unsigned          FILTER_LEN   = 4,
  parameter int unsigned          HOLD_CYCLES  = 8,
  parameter int unsigned          CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              ctrl_inc,
  input  logic              ctrl_dec,
  input  logic [N_STIM-1:0] stimuli,
  output logic              level_inc,
  output logic              level_dec,
  output logic              override_active,
  output logic [1:0]        reg_state
);

  state_e  state;
  state_e  state_n;
  logic    dir;
  logic    dir_n;
  cnt_op_e cnt_op;
  logic    req;
  logic    req_dir;
  logic    filter_done;
  logic    hold_done;
  logic    forced_c;
  logic    inc_c;
  logic    dec_c;

  stim_qualifier #(
    .N_STIM       (N_STIM),
    .INC_MASK     (INC_MASK),
    .DEC_MASK     (DEC_MASK),
    .INC_PRIORITY (INC_PRIORITY),
    .FILTER_LEN   (FILTER_LEN),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .CNT_W        (CNT_W)
  ) u_qual (
    .clk         (clk),
    .rst_n       (rst_n),
    .stimuli     (stimuli),
    .cnt_op      (cnt_op),
    .req         (req),
    .req_dir     (req_dir),
    .filter_done (filter_done),
    .hold_done   (hold_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      dir   <= DIR_INC;
    end else begin
      state <= state_n;
      dir   <= dir_n;
    end
  end

  // Next state, direction and counter command; ena low freezes everything.
  always_comb begin
    state_n = state;
    dir_n   = dir;
    cnt_op  = CNT_KEEP;
    if (ena) begin
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            dir_n   = req_dir;
            cnt_op  = CNT_LOAD1;
            state_n = (FILTER_LEN == 1) ? ST_OVERRIDE : ST_QUALIFY;
          end
        end
        ST_QUALIFY: begin
          if (!req) begin
            state_n = ST_IDLE;
          end else if (req_dir != dir) begin
            dir_n  = req_dir;
            cnt_op = CNT_LOAD1;
          end else if (filter_done) begin
            state_n = ST_OVERRIDE;
          end else begin
            cnt_op = CNT_INCR;
          end
        end
        ST_OVERRIDE: begin
          if (req && (req_dir == dir)) begin
            state_n = ST_OVERRIDE;
          end else if (req) begin
            dir_n   = req_dir;
            cnt_op  = CNT_LOAD1;
            state_n = ST_QUALIFY;
          end else if (HOLD_CYCLES == 0) begin
            state_n = ST_IDLE;
          end else begin
            cnt_op  = CNT_LOAD1;
            state_n = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (req && (req_dir == dir)) begin
            state_n = ST_OVERRIDE;
          end else if (req) begin
            dir_n   = req_dir;
            cnt_op  = CNT_LOAD1;
            state_n = ST_QUALIFY;
          end else if (hold_done) begin
            state_n = ST_IDLE;
          end else begin
            cnt_op = CNT_INCR;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Output values are derived from where the FSM is heading, so a forced
  // output appears on the same edge that enters OVERRIDE.
  always_comb begin
    forced_c = (state_n == ST_OVERRIDE) || (state_n == ST_HOLD);
    inc_c    = ctrl_inc & ~ctrl_dec;
    dec_c    = ctrl_dec & ~ctrl_inc;
    if (forced_c) begin
      inc_c = (dir_n == DIR_INC);
      dec_c = (dir_n == DIR_DEC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_inc       <= 1'b0;
      level_dec       <= 1'b0;
      override_active <= 1'b0;
      reg_state       <= 2'd0;
    end else if (!ena) begin
      level_inc       <= 1'b0;
      level_dec       <= 1'b0;
      override_active <= 1'b0;
      reg_state       <= 2'd0;
    end else begin
      level_inc       <= inc_c;
      level_dec       <= dec_c;
      override_active <= forced_c;
      reg_state       <= 2'(state_n);
    end
  end

endmodule

// File: tb/tb_mood_regulator.sv
// Bench for mood_regulator: four parameterisations share one stimulus stream and
// are checked against a run-length based reference model plus directed vectors.
module tb_mood_regulator;

  localparam int NI = 4;
  // Instance params: 0 default, 1 conflict inc-priority, 2 conflict dec-priority, 3 fast.
  localparam int          FL [NI] = '{4, 4, 4, 1};
  localparam int          HC [NI] = '{8, 8, 8, 0};
  localparam logic [6:0]  DM [NI] = '{7'b0000000, 7'b0000100, 7'b0000100, 7'b0000000};
  localparam bit          IP [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [6:0]  IM = 7'b0000010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       ctrl_inc;
  logic       ctrl_dec;
  logic [6:0] stimuli;
  logic       li [NI];
  logic       ld [NI];
  logic       ov [NI];
  logic [1:0] rs [NI];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mood_regulator u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ctrl_inc(ctrl_inc), .ctrl_dec(ctrl_dec),
    .stimuli(stimuli), .level_inc(li[0]), .level_dec(ld[0]), .override_active(ov[0]),
    .reg_state(rs[0]));

  mood_regulator #(.DEC_MASK(7'b0000100), .INC_PRIORITY(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ctrl_inc(ctrl_inc), .ctrl_dec(ctrl_dec),
    .stimuli(stimuli), .level_inc(li[1]), .level_dec(ld[1]), .override_active(ov[1]),
    .reg_state(rs[1]));

  mood_regulator #(.DEC_MASK(7'b0000100), .INC_PRIORITY(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ctrl_inc(ctrl_inc), .ctrl_dec(ctrl_dec),
    .stimuli(stimuli), .level_inc(li[2]), .level_dec(ld[2]), .override_active(ov[2]),
    .reg_state(rs[2]));

  mood_regulator #(.FILTER_LEN(1), .HOLD_CYCLES(0)) u3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ctrl_inc(ctrl_inc), .ctrl_dec(ctrl_dec),
    .stimuli(stimuli), .level_inc(li[3]), .level_dec(ld[3]), .override_active(ov[3]),
    .reg_state(rs[3]));

  // Reference model: length of the current same-direction request run, whether
  // the output is forced, and how many request-free edges have passed since release.
  int m_run    [NI];
  int m_rel    [NI];
  bit m_forced [NI];
  bit m_dir    [NI];   // 0 = increment, 1 = decrement

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      m_run[k] = 0; m_rel[k] = 0; m_forced[k] = 1'b0; m_dir[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge(int k, logic [6:0] s);
    bit ri, rd, r, rdir;
    ri   = |(s & IM);
    rd   = |(s & DM[k]);
    r    = ri | rd;
    rdir = (ri && rd) ? !IP[k] : rd;
    if (!r) begin
      if (m_forced[k]) begin
        m_rel[k]++;
        if (m_rel[k] > HC[k]) begin
          m_forced[k] = 1'b0; m_run[k] = 0; m_rel[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end else if (m_forced[k]) begin
      m_rel[k] = 0;
      if (rdir != m_dir[k]) begin
        m_forced[k] = 1'b0; m_dir[k] = rdir; m_run[k] = 1;
      end
    end else begin
      if (m_run[k] > 0 && rdir == m_dir[k]) m_run[k]++;
      else begin
        m_run[k] = 1; m_dir[k] = rdir;
      end
      if (m_run[k] >= FL[k]) begin
        m_forced[k] = 1'b1; m_rel[k] = 0;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // One clock edge: advance the model with the applied inputs, then compare all instances.
  task automatic step();
    bit ei [NI];
    bit ed [NI];
    bit eo [NI];
    int es [NI];
    for (int k = 0; k < NI; k++) begin
      if (ena) model_edge(k, stimuli);
      eo[k] = ena && m_forced[k];
      if (!ena) begin
        ei[k] = 1'b0; ed[k] = 1'b0; es[k] = 0;
      end else if (m_forced[k]) begin
        ei[k] = !m_dir[k]; ed[k] = m_dir[k]; es[k] = (m_rel[k] > 0) ? 3 : 2;
      end else begin
        ei[k] = ctrl_inc && !ctrl_dec; ed[k] = ctrl_dec && !ctrl_inc;
        es[k] = (m_run[k] > 0) ? 1 : 0;
      end
    end
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.level_inc", k), 32'(li[k]), 32'(ei[k]));
      chk($sformatf("u%0d.level_dec", k), 32'(ld[k]), 32'(ed[k]));
      chk($sformatf("u%0d.override_active", k), 32'(ov[k]), 32'(eo[k]));
      chk($sformatf("u%0d.reg_state", k), 32'(rs[k]), 32'(es[k]));
    end
  endtask

  typedef struct {
    logic       en;
    logic       ci;
    logic       cd;
    logic [6:0] st;
    logic       ei;
    logic       ed;
    logic       eo;
    logic [1:0] es;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic en, input logic ci, input logic cd, input logic [6:0] st,
                     input logic ei, input logic ed, input logic eo, input logic [1:0] es);
    vec_t v;
    v.en = en; v.ci = ci; v.cd = cd; v.st = st; v.ei = ei; v.ed = ed; v.eo = eo; v.es = es;
    vq.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ctrl_inc = 1'b0; ctrl_dec = 1'b0; stimuli = '0;
    model_reset();

    // Directed vectors for the default instance, starting from IDLE.
    add(1,1,0,7'h02, 1,0,0,1); add(1,0,1,7'h02, 0,1,0,1); add(1,1,1,7'h02, 0,0,0,1);
    add(1,1,0,7'h00, 1,0,0,0);
    for (int i = 0; i < 3; i++) add(1,0,1,7'h02, 0,1,0,1);
    add(1,0,1,7'h02, 1,0,1,2); add(1,0,1,7'h02, 1,0,1,2);
    for (int i = 0; i < 8; i++) add(1,0,1,7'h00, 1,0,1,3);
    add(1,0,1,7'h00, 0,1,0,0);
    for (int i = 0; i < 3; i++) add(1,0,0,7'h02, 0,0,0,1);
    add(1,0,0,7'h02, 1,0,1,2);
    for (int i = 0; i < 4; i++) add(1,0,1,7'h00, 1,0,1,3);
    add(1,0,1,7'h02, 1,0,1,2);
    for (int i = 0; i < 8; i++) add(1,0,1,7'h00, 1,0,1,3);
    add(1,1,0,7'h00, 1,0,0,0);
    add(1,1,0,7'h02, 1,0,0,1); add(1,1,0,7'h02, 1,0,0,1);
    for (int i = 0; i < 5; i++) add(0,1,0,7'h02, 0,0,0,0);
    add(1,1,0,7'h02, 1,0,0,1); add(1,1,0,7'h02, 1,0,1,2);

    #3;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset u%0d.outputs", k), {29'd0, li[k], ld[k], ov[k]}, 32'd0);
      chk($sformatf("reset u%0d.reg_state", k), 32'(rs[k]), 32'd0);
    end
    #19 rst_n = 1'b1;   // released mid-cycle, away from the edge

    foreach (vq[i]) begin
      ena = vq[i].en; ctrl_inc = vq[i].ci; ctrl_dec = vq[i].cd; stimuli = vq[i].st;
      step();
      chk($sformatf("vec%0d.level_inc", i), 32'(li[0]), 32'(vq[i].ei));
      chk($sformatf("vec%0d.level_dec", i), 32'(ld[0]), 32'(vq[i].ed));
      chk($sformatf("vec%0d.override_active", i), 32'(ov[0]), 32'(vq[i].eo));
      chk($sformatf("vec%0d.reg_state", i), 32'(rs[0]), 32'(vq[i].es));
    end

    // Asynchronous reset while u0 is in OVERRIDE: outputs clear without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.level_inc", 32'(li[0]), 32'd0);
    chk("async_rst.override_active", 32'(ov[0]), 32'd0);
    chk("async_rst.reg_state", 32'(rs[0]), 32'd0);
    model_reset();
    ctrl_inc = 1'b1; ctrl_dec = 1'b0; stimuli = '0;
    #1 rst_n = 1'b1;
    step();
    chk("post_rst.level_inc", 32'(li[0]), 32'd1);

    // Mask conflict and single-edge filter / zero hold.
    ctrl_inc = 1'b0; stimuli = 7'b0000110;
    step();
    chk("fast.override_first_edge", 32'(ov[3]), 32'd1);
    chk("fast.reg_state", 32'(rs[3]), 32'd2);
    chk("pri1.not_yet", 32'(ov[1]), 32'd0);
    step(); step(); step();
    chk("pri1.level_inc", 32'(li[1]), 32'd1);
    chk("pri1.level_dec", 32'(ld[1]), 32'd0);
    chk("pri0.level_inc", 32'(li[2]), 32'd0);
    chk("pri0.level_dec", 32'(ld[2]), 32'd1);
    ctrl_inc = 1'b1; ctrl_dec = 1'b1; stimuli = '0;
    step();
    chk("fast.idle_on_release", 32'(rs[3]), 32'd0);
    chk("fast.both_ctrl_inc", 32'(li[3]), 32'd0);
    chk("fast.both_ctrl_dec", 32'(ld[3]), 32'd0);
    chk("pri0.hold_forced", 32'(ld[2]), 32'd1);

    // Randomised stream with persistent mask bits so runs reach the filter length.
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] s;
      s = 7'($urandom);
      s[1] = ($urandom_range(0, 5) == 0) ? ~stimuli[1] : stimuli[1];
      s[2] = ($urandom_range(0, 7) == 0) ? ~stimuli[2] : stimuli[2];
      stimuli  = s;
      ena      = ($urandom_range(0, 15) != 0);
      ctrl_inc = 1'($urandom);
      ctrl_dec = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
